// File: rtl/calc_entry_fsm.sv
// Operand-entry FSM for the keypad calculator: builds two BCD operands and an operator from key pulses.
// Optional backspace (key 14) support is enabled by defining BACKSPACE_EN.
module calc_entry_fsm #(
    parameter int DIGITS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [3:0]                   key_in,
    output logic [1:0]                   mode,
    output logic [4*DIGITS-1:0]          operand_a,
    output logic [4*DIGITS-1:0]          operand_b,
    output logic [1:0]                   op,
    output logic [$clog2(DIGITS+1)-1:0]  cnt,
    output logic [4*DIGITS-1:0]          disp_bcd,
    output logic                         done
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [3:0] KEY_ENTER = 4'd13;
    localparam logic [3:0] KEY_CLEAR = 4'd15;
`ifdef BACKSPACE_EN
    localparam logic [3:0] KEY_BACK  = 4'd14;
`endif

    typedef enum logic [1:0] {
        ENTRY_A = 2'd0,
        ENTRY_B = 2'd1,
        RESULT  = 2'd2
    } mode_e;

    mode_e           mode_q, mode_d;
    logic [W-1:0]    operand_a_q, operand_a_d;
    logic [W-1:0]    operand_b_q, operand_b_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    disp_q, disp_d;
    logic            done_q, done_d;
`ifdef BACKSPACE_EN
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
`endif

    logic is_digit, is_op, has_room;

    // New digit enters at the least significant nibble; the top digit falls off.
    function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
        logic [W-1:0] r;
        r      = v << 4;
        r[3:0] = d;
        return r;
    endfunction

    assign is_digit = (key_in <= 4'd9);
    assign is_op    = (key_in >= 4'd10) && (key_in <= 4'd12);
    assign has_room = (cnt_q < CW'(DIGITS));

    always_comb begin
        // NOTE: every *_d takes its held value first, so no path leaves it unassigned and no latch is inferred.
        mode_d      = mode_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
`ifdef BACKSPACE_EN
        cnt_a_d     = cnt_a_q;
`endif

        if (mode_q == 2'd3 || (key_valid && key_in == KEY_CLEAR)) begin
            mode_d      = ENTRY_A;
            operand_a_d = '0;
            operand_b_d = '0;
            op_d        = 2'd0;
            cnt_d       = '0;
`ifdef BACKSPACE_EN
            cnt_a_d     = '0;
`endif
        end else if (key_valid) begin
            case (mode_q)
                ENTRY_A: begin
                    if (is_digit && has_room) begin
                        operand_a_d = shift_in(operand_a_q, key_in);
                        cnt_d       = cnt_q + CW'(1);
                    end else if (is_op && cnt_q != '0) begin
                        op_d   = 2'(key_in - 4'd10);
                        mode_d = ENTRY_B;
                        cnt_d  = '0;
`ifdef BACKSPACE_EN
                        cnt_a_d = cnt_q;
                    end else if (key_in == KEY_BACK && cnt_q != '0) begin
                        operand_a_d = operand_a_q >> 4;
                        cnt_d       = cnt_q - CW'(1);
`endif
                    end
                end
                ENTRY_B: begin
                    if (is_digit && has_room) begin
                        operand_b_d = shift_in(operand_b_q, key_in);
                        cnt_d       = cnt_q + CW'(1);
                    end else if (is_op && cnt_q == '0) begin
                        op_d = 2'(key_in - 4'd10);
                    end else if (key_in == KEY_ENTER && cnt_q != '0) begin
                        mode_d = RESULT;
                        done_d = 1'b1;
`ifdef BACKSPACE_EN
                    end else if (key_in == KEY_BACK && cnt_q != '0) begin
                        operand_b_d = operand_b_q >> 4;
                        cnt_d       = cnt_q - CW'(1);
                    end else if (key_in == KEY_BACK) begin
                        mode_d = ENTRY_A;
                        op_d   = 2'd0;
                        cnt_d  = cnt_a_q;
`endif
                    end
                end
                RESULT: begin
                    if (is_digit) begin
                        mode_d      = ENTRY_A;
                        operand_a_d = shift_in('0, key_in);
                        operand_b_d = '0;
                        op_d        = 2'd0;
                        cnt_d       = CW'(1);
                    end
                end
                default: ;
            endcase
        end

        disp_d = (mode_d == ENTRY_A) ? operand_a_d : operand_b_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (rst) begin
            mode_q      <= ENTRY_A;
            operand_a_q <= '0;
            operand_b_q <= '0;
            op_q        <= 2'd0;
            cnt_q       <= '0;
            disp_q      <= '0;
            done_q      <= 1'b0;
`ifdef BACKSPACE_EN
            cnt_a_q     <= '0;
`endif
        end else begin
            mode_q      <= mode_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            done_q      <= done_d;
`ifdef BACKSPACE_EN
            cnt_a_q     <= cnt_a_d;
`endif
        end
    end

    assign mode      = mode_q;
    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign op        = op_q;
    assign cnt       = cnt_q;
    assign disp_bcd  = disp_q;
    assign done      = done_q;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed vector table followed by random keys against a digit-list model.
module tb_calc_entry_fsm;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int CW     = $clog2(DIGITS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_valid = 1'b0;
    logic [3:0]    key_in = 4'd0;
    logic [1:0]    mode;
    logic [W-1:0]  operand_a, operand_b, disp_bcd;
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic          done;

    int checks = 0;
    int errors = 0;

    calc_entry_fsm #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_in(key_in),
        .mode(mode), .operand_a(operand_a), .operand_b(operand_b), .op(op),
        .cnt(cnt), .disp_bcd(disp_bcd), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          kv;
        logic [3:0]    key;
        logic [1:0]    mode;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [1:0]    op;
        logic [CW-1:0] cnt;
        logic          done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic kv, input int key, input int m,
                                input int a, input int b, input int o, input int c, input logic d);
        vec_t v;
        v.rst = r; v.kv = kv; v.key = 4'(key); v.mode = 2'(m);
        v.a = W'(a); v.b = W'(b); v.op = 2'(o); v.cnt = CW'(c); v.done = d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic kv, input logic [3:0] k);
        @(negedge clk);
        rst = r; key_valid = kv; key_in = k;
        @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string tag, input logic [1:0] m, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [1:0] o, input logic [CW-1:0] c,
                               input logic d);
        check($sformatf("%s mode", tag), 32'(mode), 32'(m));
        check($sformatf("%s operand_a", tag), 32'(operand_a), 32'(a));
        check($sformatf("%s operand_b", tag), 32'(operand_b), 32'(b));
        check($sformatf("%s op", tag), 32'(op), 32'(o));
        check($sformatf("%s cnt", tag), 32'(cnt), 32'(c));
        check($sformatf("%s done", tag), 32'(done), 32'(d));
        check($sformatf("%s disp_bcd", tag), 32'(disp_bcd), 32'((m == 2'd0) ? a : b));
    endtask

    // Reference model: operands are lists of entered digits, mode is a small integer.
    int          m_mode;
    logic [3:0]  q_a[$];
    logic [3:0]  q_b[$];
    int          m_op;
    logic        m_done;

    function automatic logic [W-1:0] pack(input logic [3:0] q[$]);
        logic [W-1:0] v = '0;
        foreach (q[i]) v = (v << 4) | W'(q[i]);
        return v;
    endfunction

    function automatic void model_clear();
        m_mode = 0; q_a.delete(); q_b.delete(); m_op = 0; m_done = 1'b0;
    endfunction

    function automatic void model_step(input logic r, input logic kv, input int k);
        m_done = 1'b0;
        if (r || (kv && k == 15)) begin
            model_clear();
        end else if (kv) begin
            if (k <= 9) begin
                if (m_mode == 2) begin
                    q_a.delete(); q_b.delete(); q_a.push_back(4'(k)); m_op = 0; m_mode = 0;
                end else if (m_mode == 0 && q_a.size() < DIGITS) begin
                    q_a.push_back(4'(k));
                end else if (m_mode == 1 && q_b.size() < DIGITS) begin
                    q_b.push_back(4'(k));
                end
            end else if (k <= 12) begin
                if (m_mode == 0 && q_a.size() > 0) begin
                    m_op = k - 10; m_mode = 1;
                end else if (m_mode == 1 && q_b.size() == 0) begin
                    m_op = k - 10;
                end
            end else if (k == 13) begin
                if (m_mode == 1 && q_b.size() > 0) begin
                    m_mode = 2; m_done = 1'b1;
                end
            end else begin
`ifdef BACKSPACE_EN
                if (m_mode == 0 && q_a.size() > 0) void'(q_a.pop_back());
                else if (m_mode == 1 && q_b.size() > 0) void'(q_b.pop_back());
                else if (m_mode == 1) begin
                    m_mode = 0; m_op = 0;
                end
`endif
            end
        end
    endfunction

    initial begin
        // rst kv key | mode a b op cnt done
        add(1, 0, 0,  0, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 1,  0, 'h01, 'h00, 0, 1, 0);
        add(0, 1, 2,  0, 'h12, 'h00, 0, 2, 0);
        add(0, 1, 10, 1, 'h12, 'h00, 0, 0, 0);
        add(0, 1, 3,  1, 'h12, 'h03, 0, 1, 0);
        add(0, 1, 4,  1, 'h12, 'h34, 0, 2, 0);
        add(0, 1, 13, 2, 'h12, 'h34, 0, 2, 1);
        add(0, 0, 13, 2, 'h12, 'h34, 0, 2, 0);
        add(0, 1, 13, 2, 'h12, 'h34, 0, 2, 0);
        add(0, 1, 12, 2, 'h12, 'h34, 0, 2, 0);
        add(0, 1, 7,  0, 'h07, 'h00, 0, 1, 0);
        add(0, 0, 5,  0, 'h07, 'h00, 0, 1, 0);
        add(0, 1, 15, 0, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 10, 0, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 9,  0, 'h09, 'h00, 0, 1, 0);
        add(0, 1, 8,  0, 'h98, 'h00, 0, 2, 0);
        add(0, 1, 7,  0, 'h98, 'h00, 0, 2, 0);
        add(0, 1, 15, 0, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 5,  0, 'h05, 'h00, 0, 1, 0);
        add(0, 1, 10, 1, 'h05, 'h00, 0, 0, 0);
        add(0, 1, 13, 1, 'h05, 'h00, 0, 0, 0);
        add(0, 1, 11, 1, 'h05, 'h00, 1, 0, 0);
        add(0, 1, 6,  1, 'h05, 'h06, 1, 1, 0);
        add(0, 1, 12, 1, 'h05, 'h06, 1, 1, 0);
        add(0, 1, 13, 2, 'h05, 'h06, 1, 1, 1);
        add(0, 0, 0,  2, 'h05, 'h06, 1, 1, 0);
        add(0, 1, 15, 0, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 0,  0, 'h00, 'h00, 0, 1, 0);
        add(0, 1, 10, 1, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 2,  1, 'h00, 'h02, 0, 1, 0);
        add(1, 1, 13, 0, 'h00, 'h00, 0, 0, 0);
        add(0, 0, 0,  0, 'h00, 'h00, 0, 0, 0);
        add(0, 1, 4,  0, 'h04, 'h00, 0, 1, 0);
        add(0, 1, 2,  0, 'h42, 'h00, 0, 2, 0);
`ifdef BACKSPACE_EN
        add(0, 1, 14, 0, 'h04, 'h00, 0, 1, 0);
        add(0, 1, 10, 1, 'h04, 'h00, 0, 0, 0);
        add(0, 1, 14, 0, 'h04, 'h00, 0, 1, 0);
`else
        add(0, 1, 14, 0, 'h42, 'h00, 0, 2, 0);
        add(0, 1, 10, 1, 'h42, 'h00, 0, 0, 0);
        add(0, 1, 14, 1, 'h42, 'h00, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].kv, vecs[i].key);
            compare_all($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, vecs[i].b,
                        vecs[i].op, vecs[i].cnt, vecs[i].done);
        end

        // Hand-written: enter and operator keys back to back on consecutive cycles.
        drive(1'b0, 1'b1, 4'd15);
        drive(1'b0, 1'b1, 4'd3);
        drive(1'b0, 1'b1, 4'd12);
        drive(1'b0, 1'b1, 4'd9);
        drive(1'b0, 1'b1, 4'd13);
        compare_all("b2b_enter", 2'd2, W'('h03), W'('h09), 2'd2, CW'(1), 1'b1);
        drive(1'b0, 1'b1, 4'd1);
        compare_all("b2b_newexpr", 2'd0, W'('h01), W'('h00), 2'd0, CW'(1), 1'b0);

        // Randomized phase against the digit-list model.
        drive(1'b1, 1'b0, 4'd0);
        model_clear();
        compare_all("rand_reset", 2'(m_mode), pack(q_a), pack(q_b), 2'(m_op), CW'(0), 1'b0);
        for (int n = 0; n < 3000; n++) begin
            logic       r_v, kv_v;
            logic [3:0] k_v;
            int         exp_cnt;
            r_v  = ($urandom_range(0, 99) == 0);
            kv_v = ($urandom_range(0, 3) != 0);
            k_v  = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            model_step(r_v, kv_v, int'(k_v));
            drive(r_v, kv_v, k_v);
            exp_cnt = (m_mode == 0) ? q_a.size() : q_b.size();
            compare_all($sformatf("rand%0d", n), 2'(m_mode), pack(q_a), pack(q_b),
                        2'(m_op), CW'(exp_cnt), m_done);
        end

        @(negedge clk);
        key_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
